// File: rtl/smc_seq.sv
// smc_seq: streamed SMC calculator, six transistors per batch, insertion-sorted.
// Define SMC_SEQ_CNT_EN to add the done_cnt port counting emitted results.
module smc_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mode,
  input  logic [2:0]  w,
  input  logic [2:0]  v_gs,
  input  logic [2:0]  v_ds,
  output logic        out_valid,
  output logic [9:0]  out_n
`ifdef SMC_SEQ_CNT_EN
  ,
  output logic [15:0] done_cnt
`endif
);
  typedef enum logic [1:0] {S_COL, S_CALC, S_OUT} state_t;
  state_t     r_state, w_nxt;
  logic [2:0] r_cnt;
  logic [1:0] r_mode;
  logic [6:0] r_s [6];
  logic [6:0] w_ins [6];
  logic [9:0] r_out_n;
  logic       w_acc, w_sel_id, w_tri;
  logic [2:0] w_ov;
  logic [9:0] w_w, w_o, w_d, w_id_num, w_gm_num, w_sum;
  logic [6:0] w_val, w_a, w_b, w_c;
  assign w_acc    = in_valid && in_ready;
  // the first transistor of a batch uses the live mode, later ones the latched copy
  assign w_sel_id = (r_cnt == 3'd0) ? mode[0] : r_mode[0];
  assign w_ov     = v_gs - 3'd1;
  assign w_tri    = w_ov > v_ds;
  assign w_w      = {7'd0, w};
  assign w_o      = {7'd0, w_ov};
  assign w_d      = {7'd0, v_ds};
  assign w_id_num = w_tri ? w_w * (10'd2 * w_o * w_d - w_d * w_d) : w_w * w_o * w_o;
  assign w_gm_num = 10'd2 * w_w * (w_tri ? w_d : w_o);
  assign w_val    = (v_gs == 3'd0) ? 7'd0 : 7'(w_sel_id ? w_id_num / 10'd3 : w_gm_num / 10'd3);
  always_comb begin
    w_ins[0] = (r_s[0] >= w_val) ? r_s[0] : w_val;
    for (int i = 1; i < 6; i++)
      w_ins[i] = (r_s[i] >= w_val) ? r_s[i] : (r_s[i-1] >= w_val) ? w_val : r_s[i-1];
  end
  assign w_a   = r_mode[1] ? r_s[0] : r_s[3];
  assign w_b   = r_mode[1] ? r_s[1] : r_s[4];
  assign w_c   = r_mode[1] ? r_s[2] : r_s[5];
  assign w_sum = r_mode[0] ? 10'd3 * {3'd0, w_a} + 10'd4 * {3'd0, w_b} + 10'd5 * {3'd0, w_c}
                           : {3'd0, w_a} + {3'd0, w_b} + {3'd0, w_c};
  always_ff @(posedge clk)
    r_state <= rst ? S_COL : w_nxt;
  always_comb
    w_nxt = (r_state == S_COL)  ? ((w_acc && r_cnt == 3'd5) ? S_CALC : S_COL) :
            (r_state == S_CALC) ? S_OUT : S_COL;
  always_comb begin
    in_ready  = r_state == S_COL;
    out_valid = r_state == S_OUT;
  end
  always_ff @(posedge clk)
    if (rst || r_state == S_OUT) begin
      r_cnt   <= '0;
      r_mode  <= '0;
      r_s     <= '{default: '0};
      r_out_n <= '0;
    end else begin
      if (w_acc) begin
        r_cnt <= r_cnt + 3'd1;
        r_s   <= w_ins;
        if (r_cnt == 3'd0) r_mode <= mode;
      end
      r_out_n <= (r_state == S_CALC) ? w_sum : '0;
    end
  assign out_n = r_out_n;
`ifdef SMC_SEQ_CNT_EN
  logic [15:0] r_done;
  always_ff @(posedge clk)
    r_done <= rst ? '0 : (r_state == S_OUT) ? r_done + 16'd1 : r_done;
  assign done_cnt = r_done;
`endif
endmodule

// File: tb/tb_smc_seq.sv
// tb_smc_seq: random and directed batches against a queue-based reference model.
module tb_smc_seq;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [1:0]  mode = 0;
  logic [2:0]  w = 0, v_gs = 0, v_ds = 0;
  logic        out_valid;
  logic [9:0]  out_n;
`ifdef SMC_SEQ_CNT_EN
  logic [15:0] done_cnt;
`endif
  smc_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .w(w), .v_gs(v_gs), .v_ds(v_ds), .out_valid(out_valid), .out_n(out_n)
`ifdef SMC_SEQ_CNT_EN
    , .done_cnt(done_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int v; int k;} exp_t;
  exp_t q[$];
  int   bv[$];
  int   bmode, cyc = 0, nchk = 0, nerr = 0, npulses = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int dev(input int ww, input int g, input int d, input bit id);
    int ov;
    if (g == 0) return 0;
    ov = g - 1;
    if (ov > d) return id ? ww * (2 * ov * d - d * d) / 3 : 2 * ww * d / 3;
    return id ? ww * ov * ov / 3 : 2 * ww * ov / 3;
  endfunction
  function automatic int smc(input int vals[$], input int m);
    int s[$];
    int a, b, c;
    s = vals;
    s.rsort();
    a = (m & 2) ? s[0] : s[3];
    b = (m & 2) ? s[1] : s[4];
    c = (m & 2) ? s[2] : s[5];
    return (m & 1) ? 3 * a + 4 * b + 5 * c : a + b + c;
  endfunction
  always @(negedge clk) if (!rst) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_n", int'(out_n), e.v);
        chk("pulse_latency", cyc, e.k + 1);
`ifdef SMC_SEQ_CNT_EN
        chk("done_cnt", int'(done_cnt), npulses % 65536);
`endif
        npulses++;
      end
    end else if (out_n != 0) chk("out_n_idle_zero", int'(out_n), 0);
  end
  task automatic send(input int a, input int g, input int d, input int m, input int gap, output int k);
    bit rdy;
    int n = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 0;
      w = 3'($urandom); v_gs = 3'($urandom); v_ds = 3'($urandom); mode = 2'($urandom);
    end
    do begin
      @(negedge clk);
      in_valid = 1; w = 3'(a); v_gs = 3'(g); v_ds = 3'(d); mode = 2'(m);
      rdy = in_ready;
      k = cyc + 1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    if (bv.size() == 0) bmode = m;
    bv.push_back(dev(a, g, d, bmode[0]));
    if (bv.size() == 6) begin
      q.push_back('{smc(bv, bmode), k});
      bv.delete();
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    rst = 0;
    bv.delete();
    q.delete();
    npulses = 0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_n", int'(out_n), 0);
`ifdef SMC_SEQ_CNT_EN
    chk("rst_done_cnt", int'(done_cnt), 0);
`endif
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      in_valid = 0;
      n++;
    end
    chk("drain_queue", q.size(), 0);
  endtask
  initial begin
    int k, k6;
    do_reset();
    for (int i = 0; i < 6; i++) send(3, 3, 3, 1, 0, k);
    chk("model_t1", q[0].v, 48);
    drain();
    for (int m = 3; m >= 0; m--) begin
      for (int i = 1; i <= 6; i++) send(i, 2, 7, m, i % 3, k);
      drain();
    end
    for (int i = 0; i < 5; i++) send(3, 7, 2, 1, 0, k);
    send(3, 0, 5, 1, 1, k);
    drain();
    for (int i = 0; i < 6; i++) send(7, 7, 7, 3, 0, k);
    drain();
    for (int i = 0; i < 4; i++) send(5, 6, 2, 3, 0, k);
    do_reset();
    for (int i = 0; i < 6; i++) send(3, 3, 3, 0, 0, k);
    drain();
    idle(2);
    do_reset();
    for (int i = 0; i < 6; i++) send(3, 3, 3, 1, 0, k6);
    send(2, 5, 1, 2, 0, k);
    chk("backpressure_accept", k, k6 + 3);
    for (int i = 0; i < 5; i++) send(6, 4, 3, (i == 2) ? 1 : 2, 0, k);
    drain();
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 6; i++)
        send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 2), k);
      if (b % 4 == 3) drain();
    end
    drain();
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
